// File: rtl/result_writeback_buffer.sv
// Purpose: 4-entry circular writeback buffer between execute and register file, with zero/neg flags and a dest hazard query.
// Latency: one cycle from accept to wb_valid; wb_data/wb_addr come straight from the head entry, with no pass-through.
// Backpressure: in_ready drops when full (a pop in the same cycle does not reopen it); head is held stable while wb_ready is low.
module result_writeback_buffer #(
  parameter int WORD_SIZE = 19,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_opcode,
  input  logic [WORD_SIZE-1:0] in_result,
  input  logic [3:0]           in_dest,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic [3:0]           wb_addr,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic [2:0]           count,
  input  logic [3:0]           query_addr,
  output logic                 query_hit
);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [2:0] CNT_FULL = 3'(DEPTH);

  typedef struct packed {
    logic [WORD_SIZE-1:0] result;
    logic [3:0]           dest;
  } entry_t;

  entry_t     mem_q [4];
  entry_t     mem_d [4];
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;
  logic       flag_zero_q, flag_zero_d;
  logic       flag_neg_q, flag_neg_d;
  logic       push, pop;
  logic [3:0] slot_live;
  logic [3:0] slot_match;

  // Handshake outputs depend only on registered state.
  assign in_ready  = (count_q != CNT_FULL);
  assign wb_valid  = (count_q != 3'd0);
  assign wb_data   = mem_q[head_q].result;
  assign wb_addr   = mem_q[head_q].dest;
  assign count     = count_q;
  assign flag_zero = flag_zero_q;
  assign flag_neg  = flag_neg_q;

  // NOPs complete the handshake but are dropped instead of enqueued.
  assign push = in_valid && in_ready && (in_opcode != OP_NOP);
  assign pop  = wb_valid && wb_ready;

  // Next-state for pointers, occupancy, flags and storage.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flag_zero_d = flag_zero_q;
    flag_neg_d  = flag_neg_q;
    mem_d       = mem_q;
    if (push) begin
      mem_d[tail_q] = '{result: in_result, dest: in_dest};
      tail_d        = tail_q + 2'd1;
    end
    if (pop) begin
      head_d      = head_q + 2'd1;
      flag_zero_d = (wb_data == '0);
      flag_neg_d  = wb_data[WORD_SIZE-1];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Hazard check: a slot counts only if it lies within [head, head+count) of current state.
  always_comb begin
    slot_live  = '0;
    slot_match = '0;
    for (int i = 0; i < 4; i++) begin
      slot_live[i]  = ({1'b0, 2'(i) - head_q} < count_q);
      slot_match[i] = (mem_q[i].dest == query_addr);
    end
  end

  assign query_hit = |(slot_live & slot_match);

  // Control state with asynchronous clear; in-flight entries are abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      count_q     <= 3'd0;
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flag_zero_q <= flag_zero_d;
      flag_neg_q  <= flag_neg_d;
    end
  end

  // Entry storage needs no reset; contents are only observed behind count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
